// File: rtl/round_sgf_pipe.sv
// Two-stage significand rounding unit: stage 1 decides the increment, stage 2 applies it.
// Valid/ready flow control with a saturating counter of delivered rounded-up beats.
module round_sgf_pipe #(
  parameter int unsigned SW = 23,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          In_Valid_i,
  output logic          In_Ready_o,
  input  logic [SW-1:0] Sgf_i,
  input  logic [2:0]    Grs_i,
  input  logic [1:0]    Round_Type_i,
  input  logic          Sign_Result_i,
  output logic          Out_Valid_o,
  input  logic          Out_Ready_i,
  output logic [SW-1:0] Sgf_o,
  output logic          Ovf_o,
  output logic          Round_Flag_o,
  output logic          Inexact_o,
  output logic          Sign_o,
  input  logic          Cnt_Clr_i,
  output logic [CW-1:0] Round_Cnt_o
);

  localparam int unsigned AW = SW + 1;

  localparam logic [1:0] RT_ZERO = 2'b00;
  localparam logic [1:0] RT_NEG  = 2'b01;
  localparam logic [1:0] RT_POS  = 2'b10;
  localparam logic [1:0] RT_NE   = 2'b11;

  // Stage 1 state
  logic          v1_q;
  logic [SW-1:0] sgf1_q;
  logic          sign1_q;
  logic          inexact1_q;
  logic          flag1_q;

  // Stage 2 state (drives the outputs)
  logic          v2_q;
  logic [SW-1:0] sgf2_q;
  logic          ovf2_q;
  logic          flag2_q;
  logic          inexact2_q;
  logic          sign2_q;
  logic [CW-1:0] cnt_q;

  logic          en1_c;
  logic          en2_c;
  logic          accept_c;
  logic          deliver_c;
  logic          inexact1_d;
  logic          flag1_d;
  logic [AW-1:0] sum2_d;
  logic [CW-1:0] cnt_d;

  // Handshake and stage enables
  always_comb begin
    en2_c     = ~v2_q | Out_Ready_i;
    en1_c     = ~v1_q | en2_c;
    accept_c  = In_Valid_i & en1_c;
    deliver_c = v2_q & Out_Ready_i;
  end

  // Rounding decision; nearest-even breaks ties toward an even LSB
  always_comb begin
    inexact1_d = |Grs_i;
    flag1_d    = 1'b0;
    case (Round_Type_i)
      RT_ZERO: flag1_d = 1'b0;
      RT_NEG:  flag1_d = Sign_Result_i & inexact1_d;
      RT_POS:  flag1_d = ~Sign_Result_i & inexact1_d;
      RT_NE:   flag1_d = Grs_i[2] & (Grs_i[1] | Grs_i[0] | Sgf_i[0]);
      default: flag1_d = 1'b0;
    endcase
  end

  // Increment with carry-out into the extra MSB
  always_comb begin
    sum2_d = {1'b0, sgf1_q} + AW'(flag1_q);
  end

  // Saturating counter; clear wins over a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (Cnt_Clr_i) begin
      cnt_d = '0;
    end else if (deliver_c && flag2_q && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      sgf1_q     <= '0;
      sign1_q    <= 1'b0;
      inexact1_q <= 1'b0;
      flag1_q    <= 1'b0;
      v2_q       <= 1'b0;
      sgf2_q     <= '0;
      ovf2_q     <= 1'b0;
      flag2_q    <= 1'b0;
      inexact2_q <= 1'b0;
      sign2_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (en1_c) begin
        v1_q <= accept_c;
        if (accept_c) begin
          sgf1_q     <= Sgf_i;
          sign1_q    <= Sign_Result_i;
          inexact1_q <= inexact1_d;
          flag1_q    <= flag1_d;
        end
      end
      // Data only moves with a real beat so held outputs never glitch
      if (en2_c) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sgf2_q     <= sum2_d[SW-1:0];
          ovf2_q     <= sum2_d[SW];
          flag2_q    <= flag1_q;
          inexact2_q <= inexact1_q;
          sign2_q    <= sign1_q;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign In_Ready_o   = en1_c;
  assign Out_Valid_o  = v2_q;
  assign Sgf_o        = sgf2_q;
  assign Ovf_o        = ovf2_q;
  assign Round_Flag_o = flag2_q;
  assign Inexact_o    = inexact2_q;
  assign Sign_o       = sign2_q;
  assign Round_Cnt_o  = cnt_q;

endmodule
